// File: rtl/col_sum_sweeper_if.sv
// Result stream of col_sum_sweeper: one column sum and its column index per
// valid/ready transfer.
interface col_sum_sweeper_if #(
  parameter int W = 32
);
  logic [W+1:0] out_data;
  logic [1:0]   out_col;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_col, output out_valid, input out_ready);
  modport slave  (input out_data, input out_col, input out_valid, output out_ready);
endinterface

// File: rtl/col_sum_sweeper.sv
// Counts words loaded into the 16-word buffer, then sweeps its four columns and
// streams one carry-preserving four-word sum per column before pulsing done.
module col_sum_sweeper #(
  parameter int W      = 32,
  parameter int NWORDS = 16,
  parameter int NCOL   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic           start,
  input  logic [4*W-1:0] col,
  output logic [3:0]     addr,
  output logic           busy,
  output logic           full,
  output logic           done,
  output logic           err,
  col_sum_sweeper_if.master res
);

  localparam logic [4:0] FULL_COUNT = 5'(NWORDS);
  localparam logic [3:0] LAST_COL   = 4'(NCOL - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t       state;
  logic [4:0]   count;
  logic [W+1:0] col_sum;
  logic         load_ok;
  logic         xfer;

  // Two spare top bits make the four-word sum exact, so it can never wrap.
  always_comb begin
    col_sum = '0;
    for (int i = 0; i < 4; i++) begin
      col_sum = col_sum + {2'b00, col[i*W +: W]};
    end
  end

  assign load_ok = load_en && !busy && (count != FULL_COUNT);
  assign xfer    = (state == WAIT) && res.out_valid && res.out_ready;

  // Word count, sticky error and the sweep FSM share one register block so the
  // end-of-sweep transfer can clear the count in the same edge that raises done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      addr          <= '0;
      busy          <= 1'b0;
      full          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      res.out_data  <= '0;
      res.out_col   <= '0;
      res.out_valid <= 1'b0;
    end else begin
      done <= 1'b0;

      if (load_en && busy) begin
        err <= 1'b1;
      end

      if (load_ok) begin
        count <= count + 5'd1;
        full  <= (count + 5'd1 == FULL_COUNT);
      end

      case (state)
        IDLE: begin
          if (start && full) begin
            state <= RUN;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          res.out_data  <= col_sum;
          res.out_col   <= addr[1:0];
          res.out_valid <= 1'b1;
          state         <= WAIT;
        end
        WAIT: begin
          if (xfer) begin
            res.out_valid <= 1'b0;
            if (addr == LAST_COL) begin
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
              addr  <= '0;
              count <= '0;
              full  <= 1'b0;
            end else begin
              addr  <= addr + 4'd1;
              state <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/col_sum_sweeper.md
Name: col_sum_sweeper

Overview:
- Downstream consumer of the 16-word (512-bit) shift-register buffer.
- Counts words loaded into the buffer and, on start, sweeps the buffer's column address 0..3.
- For each column, reduces the buffer's 128-bit column output (four 32-bit words) to one 34-bit sum.
- Emits the four sums one at a time over a valid/ready handshake, then pulses done.

Parameters:
- W, 32, word width; the column input is 4*W bits.
- NWORDS, 16, words required in the buffer before a sweep is allowed.
- NCOL, 4, columns per sweep (addr values 0..NCOL-1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_en  in  1  same strobe that drives the buffer's enable; one word loaded per high cycle.
- start  in  1  request a sweep; sampled on clock edges.
- col  in  4*W  buffer column output; combinational in addr. col[4W-1:3W] is word0 and col[W-1:0] is word3.
- addr  out  4  column select to the buffer.
- out_data  out  W+2  column sum.
- out_col  out  2  index of the column carried by out_data.
- out_valid  out  1  out_data/out_col valid.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  sweep in progress; upstream must hold load_en low while busy is high.
- full  out  1  word count equals NWORDS.
- done  out  1  one-cycle pulse after the last column is accepted.
- err  out  1  sticky flag: load_en was seen while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - addr=0, out_data=0, out_col=0, out_valid=0, busy=0, full=0, done=0, err=0.
  - Word count=0, FSM=IDLE.
  - Asserting reset mid-sweep aborts the sweep immediately; no done pulse is produced.
- Word counter, 5 bits:
  - Increments on each edge with load_en=1 and busy=0.
  - Saturates at NWORDS; extra loads while full do not change the count.
  - full is registered and equals (count==NWORDS).
  - load_en=1 while busy=1 does not change the count and sets err=1.
  - err stays set until reset.
- FSM states: IDLE, RUN, WAIT.
- IDLE:
  - start=1 with full=1 at an edge -> RUN, addr=0, busy=1.
  - start while full=0 is ignored; no state change.
- RUN (one cycle):
  - out_data <= zero-extended word0+word1+word2+word3 of col, taken at the current addr.
  - out_col <= addr[1:0], out_valid <= 1 -> WAIT.
  - The sum is computed at W+2 bits and never wraps; max 4*(2^W-1).
- WAIT:
  - out_valid is held; out_data and out_col are stable until the handshake.
  - Transfer occurs on an edge with out_valid=1 and out_ready=1; out_valid then drops to 0.
  - If addr==NCOL-1: -> IDLE, done=1 for exactly one cycle, busy=0, addr=0, count=0, full=0. The buffer must be reloaded before the next sweep.
  - Otherwise: addr <= addr+1 -> RUN.
- Throughput: 2 cycles minimum per column with out_ready tied high, so done asserts 8 cycles after start is accepted.
- start asserted while busy is ignored.
- done and out_valid are never high in the same cycle.
- addr changes only at the RUN entry points listed above, so col is stable during RUN.

Test Plan:
- Reset then 16 load_en pulses -> full=1 after the 16th edge. A 17th pulse leaves count at 16 and err=0.
- Buffer loaded with words 1..16, start, out_ready=1 -> four results with out_col=0,1,2,3 and sums equal to the four-word column sums. done pulses 8 cycles after start is accepted, then full=0.
- All 16 words = 0xFFFFFFFF -> each out_data=0x3FFFFFFFC; no wrap occurs.
- out_ready held low for 5 cycles on column 1 -> out_valid stays high with out_data and out_col stable and addr frozen at 1. The sweep resumes when out_ready rises.
- start with only 10 words loaded -> ignored, busy=0. load_en pulsed during a sweep -> err=1, count unchanged.
- rst pulled low while in WAIT on column 2 -> all outputs return to zero immediately with no done pulse. After release, start is ignored until 16 new loads.
